// File: rtl/ascon_perm_seq.sv
// ascon_perm_seq: iterative Ascon-p permutation engine, UNROLL (1 or 2) rounds per clock.
// Each round: constant addition (pc) -> bitsliced S-box layer (ascon_ps) -> linear layer (pl).
// Optional macro ASCON_PERM_ABORT_EN adds abort_i to cancel a RUN/DONE operation.

// One 5-bit S-box column; x_i/y_o = {x0,x1,x2,x3,x4} bits of the same column.
module ascon_sbox (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);
  logic w_a0, w_a1, w_a2, w_a3, w_a4;
  logic w_b0, w_b1, w_b2, w_b3, w_b4;

  assign w_a0 = x_i[4] ^ x_i[0];
  assign w_a1 = x_i[3];
  assign w_a2 = x_i[2] ^ x_i[3];
  assign w_a3 = x_i[1];
  assign w_a4 = x_i[0] ^ x_i[1];

  assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
  assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
  assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
  assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

  assign y_o = {w_b0 ^ w_b4, w_b1 ^ w_b0, ~w_b2, w_b3 ^ w_b2, w_b4};
endmodule

// Substitution layer: 64 independent S-box columns across the five lanes.
module ascon_ps (
  input  logic [319:0] s_i,
  output logic [319:0] s_o
);
  logic [63:0][4:0] w_y;

  for (genvar j = 0; j < 64; j++) begin : g_col
    ascon_sbox u_sbox (
      .x_i ({s_i[256+j], s_i[192+j], s_i[128+j], s_i[64+j], s_i[j]}),
      .y_o (w_y[j])
    );
    assign {s_o[256+j], s_o[192+j], s_o[128+j], s_o[64+j], s_o[j]} = w_y[j];
  end
endmodule

module ascon_perm_seq #(
  parameter int UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [319:0] S_i,
  input  logic [3:0]   rounds_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] S_o,
  output logic         busy_o
);
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_seq: UNROLL must be 1 or 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [319:0] r_x;
  logic [319:0] r_so;
  logic [3:0]   r_rnd;

  logic         w_abort;
  logic [3:0]   w_n, w_rnd_init, w_rnd_nxt;
  logic         w_step2, w_last;
  logic [319:0] w_pc1, w_ps1, w_r1, w_r2, w_next;

  // round constant for round index i: F0, E1, ..., 4B
  function automatic logic [7:0] rc(input logic [3:0] i);
    return 8'hF0 - 8'(i) * 8'h0F;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] pl(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    {x0, x1, x2, x3, x4} = s;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

`ifdef ASCON_PERM_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // 0 and anything above 12 run the full 12 rounds
  assign w_n        = (rounds_i == 4'd0 || rounds_i > 4'd12) ? 4'd12 : rounds_i;
  assign w_rnd_init = 4'd12 - w_n;

  // first round of the cycle: constant addition on x2[7:0]
  always_comb begin
    w_pc1             = r_x;
    w_pc1[135:128]    = r_x[135:128] ^ rc(r_rnd);
  end

  ascon_ps u_ps1 (.s_i(w_pc1), .s_o(w_ps1));
  assign w_r1 = pl(w_ps1);

  if (UNROLL == 2) begin : g_unroll2
    logic [319:0] w_pc2, w_ps2;
    // second round of the cycle, fed by the first
    always_comb begin
      w_pc2          = w_r1;
      w_pc2[135:128] = w_r1[135:128] ^ rc(4'(r_rnd + 4'd1));
    end
    ascon_ps u_ps2 (.s_i(w_pc2), .s_o(w_ps2));
    assign w_r2 = pl(w_ps2);
  end else begin : g_unroll1
    assign w_r2 = w_r1;
  end

  // two rounds only while at least two remain; an odd tail bypasses round two
  assign w_step2   = (UNROLL == 2) && (r_rnd <= 4'd10);
  assign w_next    = w_step2 ? w_r2 : w_r1;
  assign w_rnd_nxt = r_rnd + (w_step2 ? 4'd2 : 4'd1);
  assign w_last    = (w_rnd_nxt == 4'd12);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i)                w_state_nxt = S_RUN;
      S_RUN:   if (w_abort)                   w_state_nxt = S_IDLE;
               else if (w_last)               w_state_nxt = S_DONE;
      S_DONE:  if (w_abort || out_ready_i)    w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // datapath: latch request, iterate rounds, capture result on entry to DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x   <= '0;
      r_so  <= '0;
      r_rnd <= '0;
    end else if (r_state == S_IDLE && in_valid_i) begin
      r_x   <= S_i;
      r_rnd <= w_rnd_init;
    end else if (r_state == S_RUN && !w_abort) begin
      r_x   <= w_next;
      r_rnd <= w_rnd_nxt;
      if (w_last) r_so <= w_next;
    end
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign busy_o      = (r_state == S_RUN);
  assign S_o         = r_so;
endmodule

// File: tb/tb_ascon_perm_seq.sv
// Bench for ascon_perm_seq: UNROLL=1 and UNROLL=2 instances share stimulus; expected
// states come from a table-driven reference permutation pushed into per-instance queues.
module tb_ascon_perm_seq;
  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [319:0] S_i;
  logic [3:0]   rounds;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         rdy1, ov1, busy1, rdy2, ov2, busy2;
  logic [319:0] so1, so2;

  int ntests = 0;
  int nfail  = 0;
  logic [319:0] q1[$], q2[$];
  logic [319:0] last1, last2;

  always #5 clk = ~clk;

  ascon_perm_seq #(.UNROLL(1)) u1 (
    .clk_i(clk), .rst_i(rst),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .in_valid_i(in_valid), .in_ready_o(rdy1), .S_i(S_i), .rounds_i(rounds),
    .out_valid_o(ov1), .out_ready_i(out_ready), .S_o(so1), .busy_o(busy1));

  ascon_perm_seq #(.UNROLL(2)) u2 (
    .clk_i(clk), .rst_i(rst),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .in_valid_i(in_valid), .in_ready_o(rdy2), .S_i(S_i), .rounds_i(rounds),
    .out_valid_o(ov2), .out_ready_i(out_ready), .S_o(so2), .busy_o(busy2));

  // Ascon S-box as a lookup table, entry 0 in the top 5 bits
  localparam logic [159:0] SB = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [319:0] model(input logic [319:0] s, input int n);
    logic [63:0]  x[5];
    logic [63:0]  y[5];
    logic [127:0] d;
    logic [4:0]   v, o;
    int ra[5], rb[5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    for (int i = 12 - n; i < 12; i++) begin
      x[2][7:0] = x[2][7:0] ^ 8'((15 - i) * 16 + i);
      for (int j = 0; j < 64; j++) begin
        v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = SB[159 - 5*v -: 5];
        for (int k = 0; k < 5; k++) y[k][j] = o[4-k];
      end
      for (int k = 0; k < 5; k++) begin
        x[k] = y[k];
        d = {y[k], y[k]} >> ra[k];
        x[k] = x[k] ^ d[63:0];
        d = {y[k], y[k]} >> rb[k];
        x[k] = x[k] ^ d[63:0];
      end
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request to both instances and wait for both results (bounded).
  task automatic run_op(input logic [319:0] s, input logic [3:0] r, input string tag);
    int n, l1, l2, cyc;
    logic [319:0] e;
    n = (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
    e = model(s, n);
    q1.push_back(e);
    q2.push_back(e);
    S_i = s; rounds = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l1 = -1; l2 = -1; cyc = 0;
    while ((l1 < 0 || l2 < 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (l1 < 0 && ov1) begin l1 = cyc; e = q1.pop_front(); chk({tag, "_so_u1"}, so1, e); last1 = e; end
      if (l2 < 0 && ov2) begin l2 = cyc; e = q2.pop_front(); chk({tag, "_so_u2"}, so2, e); last2 = e; end
    end
    if (l1 < 0) q1.delete();
    if (l2 < 0) q2.delete();
    chki({tag, "_lat_u1"}, l1, n);
    chki({tag, "_lat_u2"}, l2, (n + 1) / 2);
    if (out_ready) begin
      @(posedge clk); #1;
      chki({tag, "_idle"}, int'({rdy1, rdy2, ov1, ov2}), 4'b1100);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [319:0] s;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; S_i = '0; rounds = 4'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // reset state
    chki("rst_flags_u1", int'({rdy1, ov1, busy1}), 3'b100);
    chki("rst_flags_u2", int'({rdy2, ov2, busy2}), 3'b100);
    chk("rst_so_u1", so1, '0);
    chk("rst_so_u2", so2, '0);

    // full permutation of the zero state
    run_op('0, 4'd12, "p12_zero");
    // repeated lane pattern, 8 and 6 rounds
    run_op({5{64'hfeedfacecafebeef}}, 4'd8, "fe_r8");
    run_op({5{64'hfeedfacecafebeef}}, 4'd6, "fe_r6");
    // boundaries: single round, clamp of 0 and 15, odd count with UNROLL=2
    run_op({5{64'h0123456789abcdef}}, 4'd1, "r1");
    run_op({5{64'h0123456789abcdef}}, 4'd0, "r0_clamp");
    run_op({64'h1, 64'h2, 64'h3, 64'h4, 64'h5}, 4'd15, "r15_clamp");
    run_op({5{64'hfeedfacecafebeef}}, 4'd5, "r5");

    // random states and round counts
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 10; w++) s[32*w +: 32] = $urandom;
      run_op(s, 4'($urandom_range(0, 15)), "rand");
    end

    // backpressure in DONE: output held, input ignored
    out_ready = 1'b0;
    run_op({5{64'hfeedfacecafebeef}}, 4'd4, "bp");
    S_i = '1; rounds = 4'd3; in_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      chki("bp_hold_flags", int'({ov1, rdy1, ov2, rdy2}), 4'b1010);
      chk("bp_hold_so_u1", so1, last1);
      chk("bp_hold_so_u2", so2, last2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chki("bp_release", int'({rdy1, ov1, rdy2, ov2}), 4'b1010);
    chk("bp_after_so_u1", so1, last1);

`ifdef ASCON_PERM_ABORT_EN
    // abort on the 5th RUN cycle: back to idle, result register untouched
    S_i = {5{64'h55aa55aa33cc33cc}}; rounds = 4'd12; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chki("ab_busy", int'({busy1, busy2}), 2'b11);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chki("ab_flags", int'({rdy1, ov1, busy1, rdy2, ov2, busy2}), 6'b100100);
    chk("ab_so_u1", so1, last1);
    chk("ab_so_u2", so2, last2);
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (ov1 || ov2) seen++; end
    chki("ab_no_valid", seen, 0);
`endif

    // synchronous reset on the 5th RUN cycle
    S_i = {5{64'h55aa55aa33cc33cc}}; rounds = 4'd12; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chki("mr_busy", int'({busy1, busy2}), 2'b11);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chki("mr_flags", int'({rdy1, ov1, busy1, rdy2, ov2, busy2}), 6'b100100);
    chk("mr_so_u1", so1, '0);
    chk("mr_so_u2", so2, '0);
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (ov1 || ov2) seen++; end
    chki("mr_no_valid", seen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
